// File: rtl/axi4_rd_intc_m2s_outstd_if.sv
// Bundle of the NUM upstream read ports and the single downstream read port.
// Pure wiring, no latency; handshakes follow AXI valid/ready rules.
// The "slave" view belongs to the interconnect, "master" to whatever drives it.
interface axi4_rd_intc_m2s_outstd_if #(
  parameter int NUM     = 4,
  parameter int SIDSIZE = 4,
  parameter int ASIZE   = 32,
  parameter int LSIZE   = 8,
  parameter int DSIZE   = 64
);
  localparam int NSIZE   = ($clog2(NUM) > 1) ? $clog2(NUM) : 1;
  localparam int MIDSIZE = SIDSIZE + NSIZE;

  logic [NUM*SIDSIZE-1:0] s_arid;
  logic [NUM*ASIZE-1:0]   s_araddr;
  logic [NUM*LSIZE-1:0]   s_arlen;
  logic [NUM-1:0]         s_arvalid;
  logic [NUM-1:0]         s_arready;
  logic [NUM*SIDSIZE-1:0] s_rid;
  logic [NUM*DSIZE-1:0]   s_rdata;
  logic [NUM-1:0]         s_rlast;
  logic [NUM-1:0]         s_rvalid;
  logic [NUM-1:0]         s_rready;
  logic [MIDSIZE-1:0]     m_arid;
  logic [ASIZE-1:0]       m_araddr;
  logic [LSIZE-1:0]       m_arlen;
  logic                   m_arvalid;
  logic                   m_arready;
  logic [MIDSIZE-1:0]     m_rid;
  logic [DSIZE-1:0]       m_rdata;
  logic                   m_rlast;
  logic                   m_rvalid;
  logic                   m_rready;

  modport slave (
    input  s_arid, s_araddr, s_arlen, s_arvalid, s_rready,
    output s_arready, s_rid, s_rdata, s_rlast, s_rvalid,
    output m_arid, m_araddr, m_arlen, m_arvalid, m_rready,
    input  m_arready, m_rid, m_rdata, m_rlast, m_rvalid
  );

  modport master (
    output s_arid, s_araddr, s_arlen, s_arvalid, s_rready,
    input  s_arready, s_rid, s_rdata, s_rlast, s_rvalid,
    input  m_arid, m_araddr, m_arlen, m_arvalid, m_rready,
    output m_arready, m_rid, m_rdata, m_rlast, m_rvalid
  );
endinterface

// File: rtl/axi4_rd_intc_m2s_outstd.sv
// NUM-to-1 AXI4 read interconnect: round-robin AR mux, ID-routed R demux, per-port burst limit.
// Latency: AR one register stage; R zero cycles (R_PIPE=0) or one registered cycle (R_PIPE=1).
// Backpressure: AR held off per port at MAX_OUTSTD or when the AR register is full; R stalls in order.
module axi4_rd_intc_m2s_outstd #(
  parameter int NUM        = 4,
  parameter int SIDSIZE    = 4,
  parameter int ASIZE      = 32,
  parameter int LSIZE      = 8,
  parameter int DSIZE      = 64,
  parameter int MAX_OUTSTD = 4,
  parameter int R_PIPE     = 1,
  localparam int NSIZE     = ($clog2(NUM) > 1) ? $clog2(NUM) : 1,
  localparam int MIDSIZE   = SIDSIZE + NSIZE,
  localparam int CSIZE     = $clog2(MAX_OUTSTD + 1)
) (
  input  logic                     axi_aclk,
  input  logic                     axi_aresetn,
  axi4_rd_intc_m2s_outstd_if.slave bus,
  output logic [NUM*CSIZE-1:0]     outstd_cnt,
  output logic [1:0]               err
);
  localparam int NPAD = 1 << NSIZE;
  localparam logic [NSIZE:0]   NUM_W = (NSIZE + 1)'(NUM);
  localparam logic [CSIZE-1:0] MAX_W = CSIZE'(MAX_OUTSTD);

  typedef logic [NSIZE-1:0] port_t;
  typedef struct packed {
    logic [SIDSIZE-1:0] sid;
    port_t              port;
    logic [DSIZE-1:0]   data;
    logic               last;
  } beat_t;

  logic [CSIZE-1:0]   cnt_q [NUM];
  logic [CSIZE-1:0]   cnt_d [NUM];
  logic [NUM-1:0]     elig, sar;
  port_t              ptr_q, ptr_d, gnt_idx;
  logic               gnt_vld, ar_load;
  logic               m_arvalid_q, m_arvalid_d;
  logic [MIDSIZE-1:0] m_arid_q, m_arid_d;
  logic [ASIZE-1:0]   m_araddr_q, m_araddr_d;
  logic [LSIZE-1:0]   m_arlen_q, m_arlen_d;
  logic [1:0]         err_q, err_d;

  // R output stage, shared by both R_PIPE variants
  port_t              in_port;
  logic               in_ok;
  logic [NPAD-1:0]    rdy_pad;
  logic               r_vld, r_last, r_pop;
  port_t              r_port;
  logic [SIDSIZE-1:0] r_sid;
  logic [DSIZE-1:0]   r_data;

  assign in_port = bus.m_rid[NSIZE-1:0];
  assign in_ok   = ({1'b0, in_port} < NUM_W);
  assign rdy_pad = NPAD'(bus.s_rready);
  assign r_pop   = r_vld && rdy_pad[r_port];

  // A port may compete only while it has room for another burst
  always_comb begin
    elig = '0;
    for (int k = 0; k < NUM; k++) elig[k] = bus.s_arvalid[k] && (cnt_q[k] < MAX_W);
  end

  // Round-robin search: first eligible port at or after the pointer
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    for (int i = 0; i < NUM; i++) begin
      if (!gnt_vld && elig[(int'(ptr_q) + i) % NUM]) begin
        gnt_vld = 1'b1;
        gnt_idx = port_t'((int'(ptr_q) + i) % NUM);
      end
    end
  end

  assign ar_load = !m_arvalid_q || bus.m_arready;

  // Only the winner sees ready, and only when the AR register can take it
  always_comb begin
    sar = '0;
    for (int k = 0; k < NUM; k++) sar[k] = ar_load && gnt_vld && (gnt_idx == port_t'(k));
  end
  assign bus.s_arready = sar;

  // AR register next state; port index rides in the low ARID bits
  always_comb begin
    m_arvalid_d = m_arvalid_q;
    m_arid_d    = m_arid_q;
    m_araddr_d  = m_araddr_q;
    m_arlen_d   = m_arlen_q;
    ptr_d       = ptr_q;
    if (ar_load) begin
      m_arvalid_d = gnt_vld;
      if (gnt_vld) begin
        m_arid_d   = {bus.s_arid[gnt_idx*SIDSIZE +: SIDSIZE], gnt_idx};
        m_araddr_d = bus.s_araddr[gnt_idx*ASIZE +: ASIZE];
        m_arlen_d  = bus.s_arlen[gnt_idx*LSIZE +: LSIZE];
        ptr_d      = (gnt_idx == port_t'(NUM - 1)) ? '0 : gnt_idx + 1'b1;
      end
    end
  end

  assign bus.m_arvalid = m_arvalid_q;
  assign bus.m_arid    = m_arid_q;
  assign bus.m_araddr  = m_araddr_q;
  assign bus.m_arlen   = m_arlen_q;

  // Burst counters and sticky error flags
  always_comb begin
    err_d    = err_q;
    err_d[0] = err_q[0] | (bus.m_rvalid && !in_ok);
    for (int k = 0; k < NUM; k++) begin
      cnt_d[k] = cnt_q[k];
      if (sar[k] && !(r_pop && r_last && r_port == port_t'(k))) begin
        cnt_d[k] = cnt_q[k] + 1'b1;
      end else if (!sar[k] && r_pop && r_last && r_port == port_t'(k)) begin
        if (cnt_q[k] == '0) err_d[1] = 1'b1;
        else                cnt_d[k] = cnt_q[k] - 1'b1;
      end
    end
  end

  // Flatten counters for the status port
  always_comb begin
    outstd_cnt = '0;
    for (int k = 0; k < NUM; k++) outstd_cnt[k*CSIZE +: CSIZE] = cnt_q[k];
  end
  assign err = err_q;

  // Fan the R stage out; only the addressed port sees valid
  always_comb begin
    bus.s_rid   = {NUM{r_sid}};
    bus.s_rdata = {NUM{r_data}};
    bus.s_rlast = {NUM{r_last}};
    bus.s_rvalid = '0;
    for (int k = 0; k < NUM; k++) bus.s_rvalid[k] = r_vld && (r_port == port_t'(k));
  end

  // AR path, counter and flag state
  always_ff @(posedge axi_aclk) begin
    if (!axi_aresetn) begin
      m_arvalid_q <= 1'b0;
      m_arid_q    <= '0;
      m_araddr_q  <= '0;
      m_arlen_q   <= '0;
      ptr_q       <= '0;
      err_q       <= '0;
      for (int k = 0; k < NUM; k++) cnt_q[k] <= '0;
    end else begin
      m_arvalid_q <= m_arvalid_d;
      m_arid_q    <= m_arid_d;
      m_araddr_q  <= m_araddr_d;
      m_arlen_q   <= m_arlen_d;
      ptr_q       <= ptr_d;
      err_q       <= err_d;
      for (int k = 0; k < NUM; k++) cnt_q[k] <= cnt_d[k];
    end
  end

  if (R_PIPE == 0) begin : g_rcomb
    // Straight-through R: beats to a nonexistent port are swallowed
    always_comb begin
      r_vld  = bus.m_rvalid && in_ok;
      r_port = in_port;
      r_sid  = bus.m_rid[MIDSIZE-1:NSIZE];
      r_data = bus.m_rdata;
      r_last = bus.m_rlast;
    end
    assign bus.m_rready = in_ok ? rdy_pad[in_port] : 1'b1;
  end else begin : g_rpipe
    beat_t      e0_q, e0_d, e1_q, e1_d, in_beat;
    logic [1:0] occ_q, occ_d;
    logic       push;

    assign in_beat      = {bus.m_rid[MIDSIZE-1:NSIZE], in_port, bus.m_rdata, bus.m_rlast};
    assign push         = bus.m_rvalid && in_ok && (occ_q != 2'd2);
    assign bus.m_rready = (occ_q != 2'd2) || !in_ok;

    // e0 is the head seen by the ports; e1 only fills when the head stalls
    always_comb begin
      e0_d  = e0_q;
      e1_d  = e1_q;
      occ_d = occ_q;
      case (occ_q)
        2'd0: if (push) begin e0_d = in_beat; occ_d = 2'd1; end
        2'd1: begin
          if (push && r_pop)  e0_d = in_beat;
          else if (push)      begin e1_d = in_beat; occ_d = 2'd2; end
          else if (r_pop)     occ_d = 2'd0;
        end
        default: if (r_pop) begin e0_d = e1_q; occ_d = 2'd1; end
      endcase
    end

    // Head entry drives the port side
    always_comb begin
      r_vld  = (occ_q != 2'd0);
      r_port = e0_q.port;
      r_sid  = e0_q.sid;
      r_data = e0_q.data;
      r_last = e0_q.last;
    end

    // Skid buffer storage
    always_ff @(posedge axi_aclk) begin
      if (!axi_aresetn) begin
        e0_q  <= '0;
        e1_q  <= '0;
        occ_q <= '0;
      end else begin
        e0_q  <= e0_d;
        e1_q  <= e1_d;
        occ_q <= occ_d;
      end
    end
  end
endmodule

// File: doc/axi4_rd_intc_m2s_outstd.md
Name: axi4_rd_intc_M2S_outstd

Overview:
- NUM-to-1 AXI4 read-channel interconnect with round-robin AR arbitration and ID-based R routing.
- Adds a per-slaver outstanding-burst limit with AR backpressure, an optional R-channel register slice, and sticky error flags for misrouted or unexpected R bursts.
- Sits between NUM read masters and one shared AXI4 read slave, for example a DDR controller port.

Parameters:
- NUM, 4, number of slaver ports (>=2). NSIZE = max(1, $clog2(NUM)).
- SIDSIZE, 4, slaver ARID/RID width. Master ID width MIDSIZE = SIDSIZE+NSIZE.
- ASIZE, 32, address width.
- LSIZE, 8, ARLEN width.
- DSIZE, 64, RDATA width.
- MAX_OUTSTD, 4, maximum bursts in flight per slaver (>=1). CSIZE = $clog2(MAX_OUTSTD+1).
- R_PIPE, 1, 0 = combinational R path; 1 = 2-entry full-throughput R skid buffer.

Ports:
- axi_aclk  in  1  clock
- axi_aresetn  in  1  synchronous active-low reset
- s_arid  in  NUM*SIDSIZE  per-port ARID; port k occupies bits [k*SIDSIZE +: SIDSIZE], and the same packing applies to all flattened buses
- s_araddr  in  NUM*ASIZE  per-port ARADDR
- s_arlen  in  NUM*LSIZE  per-port ARLEN
- s_arvalid  in  NUM  per-port ARVALID
- s_arready  out  NUM  per-port ARREADY
- s_rid  out  NUM*SIDSIZE  per-port RID
- s_rdata  out  NUM*DSIZE  per-port RDATA
- s_rlast  out  NUM  per-port RLAST
- s_rvalid  out  NUM  per-port RVALID
- s_rready  in  NUM  per-port RREADY
- m_arid  out  MIDSIZE  master ARID
- m_araddr  out  ASIZE  master ARADDR
- m_arlen  out  LSIZE  master ARLEN
- m_arvalid  out  1  master ARVALID
- m_arready  in  1  master ARREADY
- m_rid  in  MIDSIZE  master RID
- m_rdata  in  DSIZE  master RDATA
- m_rlast  in  1  master RLAST
- m_rvalid  in  1  master RVALID
- m_rready  out  1  master RREADY
- outstd_cnt  out  NUM*CSIZE  per-port in-flight burst count
- err  out  2  sticky flags; bit0 = RID port index >= NUM; bit1 = RLAST to a port whose count is 0

Behaviour:
- Reset (axi_aresetn=0 at a clock edge):
  - m_arvalid, s_rvalid, all counters and err clear to 0.
  - Round-robin pointer resets to 0; skid buffer is emptied.
  - m_ar*/s_r* data fields reset to 0.
  - Reset mid-burst discards in-flight state; no recovery is attempted.
- AR eligibility: port k is eligible iff s_arvalid[k] && outstd_cnt[k] < MAX_OUTSTD.
- AR arbitration:
  - Round-robin over eligible ports, starting at the pointer. After granting k, the pointer becomes (k+1) mod NUM.
  - With no eligible port, the pointer holds.
- AR output register:
  - One-entry register. It loads when empty or when m_arvalid && m_arready in the same cycle, giving back-to-back throughput of one AR per cycle.
  - s_arready[k] = 1 only for the granted port in a load cycle. s_arready is 0 for ineligible ports even when the register is empty.
  - Latency: slaver handshake at cycle t gives m_arvalid=1 from t+1.
  - Register contents are m_arid = {s_arid[k], k[NSIZE-1:0]}, m_araddr, m_arlen.
  - m_ar* are stable while m_arvalid && !m_arready.
- Outstanding counter per port:
  - +1 on an s_ar handshake; -1 on an s_r handshake with s_rlast.
  - Both in the same cycle: unchanged.
  - -1 when the count is 0: the count stays 0 and err[1] is set.
  - The count never exceeds MAX_OUTSTD.
- R routing:
  - Port p = m_rid[NSIZE-1:0]; s_rid[p] = m_rid[MIDSIZE-1:NSIZE]; rdata and rlast are broadcast.
  - s_rvalid[p] = valid; other ports see s_rvalid = 0.
  - R_PIPE=0: m_rready = s_rready[p]; zero latency.
  - R_PIPE=1: 2-entry skid buffer. m_rready = buffer not full. Output is registered with 1-cycle latency and sustains 1 beat per cycle. Ordering is preserved and a stalled port blocks the channel (no reordering).
- Invalid port (p >= NUM, possible only when NUM is not a power of two):
  - The beat is accepted and dropped: m_rready = 1 for it and no s_rvalid is raised.
  - err[0] is set.
- err bits are cleared by reset only.
- Interleaved R bursts from different ports are legal; routing is per beat.

Test Plan:
- NUM=4, MAX_OUTSTD=4: ports 0-3 hold arvalid with m_arready=1 -> grants in order 0,1,2,3,0 in consecutive cycles; m_arid low bits 0,1,2,3; all outstd_cnt reach 2 after 8 cycles.
- Port 1 issues 4 ARs with no R returned -> outstd_cnt[1]=4 and s_arready[1]=0 thereafter. Port 2 is still granted. One RLAST beat to port 1 -> count 3 and the next AR from port 1 is accepted.
- m_arready=0 for 5 cycles with one pending request -> m_arvalid stays 1 and m_ar* remain constant. No other s_arready asserts.
- R_PIPE=1: 8-beat burst with m_rid={3'h5,2'd2} and s_rready[2] toggling 1,0,1,0 -> port 2 receives all 8 beats in order, rid=5, rlast on beat 8. No beats are lost, and m_rready drops only when 2 entries are held.
- NUM=3: beat with m_rid port field 3 -> m_rready=1, no s_rvalid, err=2'b01. RLAST to idle port 0 -> err=2'b11 and the count stays 0.
- Synchronous reset asserted mid-burst with outstd_cnt[0]=2 -> next cycle all counters 0, m_arvalid=0, s_rvalid=0, err=0.
